// File: rtl/serial_word_adder_ctrl.sv
// serial_word_adder_ctrl: byte-serial add/subtract sequencer.
// One shared 8-bit ripple adder is stepped across the operands LSB byte
// first, with the carry chained through a register between cycles.
//
// Handshake: a request is accepted when start=1 is sampled on a rising
// edge while the sequencer is idle (busy=0). start while busy=1 is dropped,
// with no queueing. done is a one-cycle pulse marking sum/cout/ovf valid.
// Those outputs then hold until the next accepted start.

// 8-bit ripple-carry adder; the single arithmetic resource of the block.
module serial_word_adder_byte (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_ci,
  output logic [7:0] o_s,
  output logic       o_co
);

  // Bit-by-bit ripple: sum bit and carry propagate from bit 0 upward.
  always_comb begin : ripple
    logic v_c;
    v_c = i_ci;
    o_s = '0;
    for (int k = 0; k < 8; k++) begin
      o_s[k] = i_a[k] ^ i_b[k] ^ v_c;
      v_c    = (i_a[k] & i_b[k]) | (v_c & (i_a[k] ^ i_b[k]));
    end
    o_co = v_c;
  end

endmodule

module serial_word_adder_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic [1:0]            o_dbg_state
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;       // already inverted for subtract
  logic [W-1:0]    r_sum;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;

  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic            w_busy;
  logic            w_done;
  logic [7:0]      w_byte_a;
  logic [7:0]      w_byte_b;
  logic [7:0]      w_byte_s;
  logic            w_byte_co;

  // Current operand bytes selected by the byte index.
  assign w_byte_a = r_a[8*r_idx +: 8];
  assign w_byte_b = r_b[8*r_idx +: 8];
  assign w_last   = (r_idx == LAST_IDX);

  serial_word_adder_byte u_byte_adder (
    .i_a  (w_byte_a),
    .i_b  (w_byte_b),
    .i_ci (r_carry),
    .o_s  (w_byte_s),
    .o_co (w_byte_co)
  );

  // State register; reset returns to IDLE and drops any start in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, byte stepping and result assembly.
  // cout/ovf are captured on the final RUN edge so they are valid during DONE
  // and stay untouched by later starts until the next operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (w_step) begin
      r_sum[8*r_idx +: 8] <= w_byte_s;
      r_carry             <= w_byte_co;
      if (w_last) begin
        r_cout <= w_byte_co;
        r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_byte_s[7] != r_a[W-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule
